inst_fetcher: RTL

- Front-end fetch stage directly upstream of the memory controller's instruction port.
- Holds the PC and issues one word request at a time to the memory controller (`inst_in_flg`/`inst_addr`).
- Captures each returned 32-bit word into an instruction queue, which the decoder/issue stage drains.
- Flushes and redirects on a misprediction/exception clear from the commit stage.

---
 rtl/inst_fetcher_pkg.sv | 24 ++
 rtl/inst_fetcher_inst_queue.sv | 57 +++++
 rtl/inst_fetcher.sv | 112 +++++++++++
 3 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetch stage: defaults, JAL opcode,
// queue entry layout, request FSM states and J-immediate extraction.
package inst_fetcher_pkg;

  localparam int unsigned QUEUE_DEPTH_LOG_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam logic [6:0]  OPC_JAL = 7'b1101111;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } q_entry_t;

  function automatic logic [31:0] jal_imm(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetcher_inst_queue.sv
// Circular instruction queue with push/pop/clear; pointers wrap naturally and
// count carries one extra bit so a full queue is distinguishable from empty.
module inst_queue #(
  parameter int unsigned DEPTH_LOG = 4,
  parameter int unsigned WIDTH     = 65
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head_data,
  output logic [DEPTH_LOG:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // A pop frees a slot in the same cycle, so push is accepted even when full
  assign do_pop    = pop && (count != '0);
  assign do_push   = push && (!count[DEPTH_LOG] || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && !clr && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: PC, single-outstanding request FSM and instruction queue.
// Define JAL_PREDECODE_EN to redirect the PC on returned JAL words.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH_LOG = QUEUE_DEPTH_LOG_DEF,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  output logic        mc_inst_flg,
  output logic [31:0] mc_inst_addr,
  input  logic        mc_ret_flg,
  input  logic [31:0] mc_ret_data,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_pred_taken,
  input  logic        out_ready
);

  localparam int unsigned DEPTH = 1 << QUEUE_DEPTH_LOG;

  fetch_state_e             state, state_nx;
  logic [31:0]              pc, pc_nx, next_pc;
  logic                     pred;
  logic                     clr;
  logic                     push;
  logic                     pop;
  q_entry_t                 push_ent;
  q_entry_t                 head_ent;
  logic [QUEUE_DEPTH_LOG:0] count;
  logic                     not_full;

`ifdef JAL_PREDECODE_EN
  always_comb begin
    pred    = (mc_ret_data[6:0] == OPC_JAL);
    next_pc = pred ? (pc + jal_imm(mc_ret_data)) : (pc + 32'd4);
  end
`else
  always_comb begin
    pred    = 1'b0;
    next_pc = pc + 32'd4;
  end
`endif

  // Clear only takes effect on a cycle where the stage is allowed to advance
  assign clr      = clear & rdy;
  assign not_full = count < (QUEUE_DEPTH_LOG + 1)'(DEPTH);
  assign pop      = out_ready & ~clr;
  assign push_ent = '{inst: mc_ret_data, pc: pc, pred: pred};

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    push        = 1'b0;
    mc_inst_flg = 1'b0;
    unique case (state)
      S_IDLE: if (not_full) state_nx = S_WAIT;
      S_WAIT: begin
        mc_inst_flg = ~mc_ret_flg;
        if (mc_ret_flg) begin
          push     = 1'b1;
          pc_nx    = next_pc;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (clr) begin
      state_nx    = S_IDLE;
      pc_nx       = clear_pc;
      push        = 1'b0;
      mc_inst_flg = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else if (rdy) begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  inst_queue #(
    .DEPTH_LOG (QUEUE_DEPTH_LOG),
    .WIDTH     ($bits(q_entry_t))
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .clr       (clr),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .head_data (head_ent),
    .count     (count)
  );

  assign mc_inst_addr   = pc;
  assign out_valid      = (count != '0);
  assign out_inst       = head_ent.inst;
  assign out_pc         = head_ent.pc;
  assign out_pred_taken = out_valid & head_ent.pred;

endmodule
